// File: rtl/grid_io_pkg.sv
// grid_io_pkg
//   Shared definitions for the I/O grid tile configuration slice.
//   - OE_BIT / INV_BIT : position of each control bit within a subtile's
//                        configuration slice
//   - io_cfg_t         : decoded per-pad configuration {oe, inv}
//   - extract_io_cfg   : decodes the two low bits of a subtile slice

package grid_io_pkg;

  localparam int OE_BIT  = 0;
  localparam int INV_BIT = 1;

  typedef struct packed {
    logic oe;
    logic inv;
  } io_cfg_t;

  function automatic io_cfg_t extract_io_cfg(input logic [1:0] slice);
    io_cfg_t c;
    c.oe  = slice[OE_BIT];
    c.inv = slice[INV_BIT];
    return c;
  endfunction

endpackage

// File: rtl/grid_io_subtile_cfg.sv
// grid_io_subtile_cfg
//   Combinational datapath of one pad subtile: applies output enable,
//   input polarity and global isolation to a single pad.
//   Ports:
//     cfg         in  io_cfg_t  active configuration {oe, inv}
//     isol_n      in  1         active-low isolation
//     pin_outpad  in  1         fabric -> pad data
//     soc_in      in  1         pad -> fabric data
//     pin_inpad   out 1         data to the fabric
//     soc_out     out 1         data to the pad
//     soc_dir     out 1         1 = input (driver off), 0 = driven

module grid_io_subtile_cfg
  import grid_io_pkg::*;
(
  input  io_cfg_t cfg,
  input  logic    isol_n,
  input  logic    pin_outpad,
  input  logic    soc_in,
  output logic    pin_inpad,
  output logic    soc_out,
  output logic    soc_dir
);

  assign soc_dir   = ~(cfg.oe & isol_n);
  assign soc_out   = isol_n & pin_outpad;
  assign pin_inpad = isol_n & (soc_in ^ cfg.inv);

endmodule

// File: rtl/grid_io_tile_cfg.sv
// grid_io_tile_cfg
//   I/O grid tile holding NUM_SUBTILES pad subtiles on one configuration
//   chain segment clocked by prog_clk.
//   Optional feature macro: GRID_IO_TILE_CFG_SHADOW_EN
//     defined   : a shadow register captures the chain on cfg_commit and
//                 drives the pads, so pads stay stable while shifting
//     undefined : the pads are driven directly from the chain
//   Ports:
//     prog_clk, prog_reset            clock, synchronous active-high reset
//     ccff_head, ccff_shift_en        serial config input and shift enable
//     cfg_commit                      commit pulse (clears the bit counter)
//     isol_n                          active-low isolation of all pads
//     pin_outpad, gfpga_pad_io_soc_in pad data inputs
//     pin_inpad, gfpga_pad_io_soc_out,
//     gfpga_pad_io_soc_dir            pad data / direction outputs
//     ccff_tail                       serial config output
//     cfg_done                        TOTAL bits shifted since reset/commit

module grid_io_tile_cfg
  import grid_io_pkg::*;
#(
  parameter int NUM_SUBTILES    = 4,
  parameter int CFG_BITS_PER_IO = 2
) (
  input  logic                    prog_clk,
  input  logic                    prog_reset,
  input  logic                    ccff_head,
  input  logic                    ccff_shift_en,
  input  logic                    cfg_commit,
  input  logic                    isol_n,
  input  logic [NUM_SUBTILES-1:0] pin_outpad,
  input  logic [NUM_SUBTILES-1:0] gfpga_pad_io_soc_in,
  output logic [NUM_SUBTILES-1:0] pin_inpad,
  output logic [NUM_SUBTILES-1:0] gfpga_pad_io_soc_out,
  output logic [NUM_SUBTILES-1:0] gfpga_pad_io_soc_dir,
  output logic                    ccff_tail,
  output logic                    cfg_done
);

  localparam int TOTAL = NUM_SUBTILES * CFG_BITS_PER_IO;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOTAL_CNT = CW'(TOTAL);

  logic [TOTAL-1:0] chain;
  logic [TOTAL-1:0] act;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    cnt_nxt;

  // A commit wins over a coincident shift: the counter restarts at zero and
  // that shift is not counted, although the chain itself still moves.
  always_comb begin
    cnt_nxt = bit_cnt;
    if (cfg_commit)
      cnt_nxt = '0;
    else if (ccff_shift_en && (bit_cnt != TOTAL_CNT))
      cnt_nxt = bit_cnt + 1'b1;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain    <= '0;
      bit_cnt  <= '0;
      cfg_done <= 1'b0;
    end else begin
      if (ccff_shift_en)
        chain <= {chain[TOTAL-2:0], ccff_head};
      bit_cnt  <= cnt_nxt;
      cfg_done <= (cnt_nxt == TOTAL_CNT);
    end
  end

  assign ccff_tail = chain[TOTAL-1];

`ifdef GRID_IO_TILE_CFG_SHADOW_EN
  logic [TOTAL-1:0] shadow;

  // Captures the chain as it was before this edge, even if it shifts now.
  always_ff @(posedge prog_clk) begin
    if (prog_reset)
      shadow <= '0;
    else if (cfg_commit)
      shadow <= chain;
  end

  assign act = shadow;
`else
  assign act = chain;
`endif

  for (genvar k = 0; k < NUM_SUBTILES; k++) begin : g_sub
    io_cfg_t sub_cfg;

    // Bits above INV_BIT in each slice are carried by the chain only.
    assign sub_cfg = extract_io_cfg(act[k*CFG_BITS_PER_IO +: 2]);

    grid_io_subtile_cfg u_sub (
      .cfg        (sub_cfg),
      .isol_n     (isol_n),
      .pin_outpad (pin_outpad[k]),
      .soc_in     (gfpga_pad_io_soc_in[k]),
      .pin_inpad  (pin_inpad[k]),
      .soc_out    (gfpga_pad_io_soc_out[k]),
      .soc_dir    (gfpga_pad_io_soc_dir[k])
    );
  end

endmodule

// File: tb/tb_grid_io_tile_cfg.sv
// tb_grid_io_tile_cfg
//   Self-checking bench for grid_io_tile_cfg (NUM_SUBTILES=4,
//   CFG_BITS_PER_IO=2). Follows GRID_IO_TILE_CFG_SHADOW_EN if defined.

module tb_grid_io_tile_cfg;

  localparam int NS    = 4;
  localparam int CB    = 2;
  localparam int TOTAL = NS * CB;

`ifdef GRID_IO_TILE_CFG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          cfg_commit;
  logic          isol_n;
  logic [NS-1:0] pin_outpad;
  logic [NS-1:0] soc_in;
  logic [NS-1:0] pin_inpad;
  logic [NS-1:0] soc_out;
  logic [NS-1:0] soc_dir;
  logic          ccff_tail;
  logic          cfg_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: most recent shifted bit first; shadow snapshot array.
  bit q[$];
  bit m_shadow[TOTAL];
  int m_cnt;

  always #5 prog_clk = ~prog_clk;

  grid_io_tile_cfg #(.NUM_SUBTILES(NS), .CFG_BITS_PER_IO(CB)) dut (
    .prog_clk             (prog_clk),
    .prog_reset           (prog_reset),
    .ccff_head            (ccff_head),
    .ccff_shift_en        (ccff_shift_en),
    .cfg_commit           (cfg_commit),
    .isol_n               (isol_n),
    .pin_outpad           (pin_outpad),
    .gfpga_pad_io_soc_in  (soc_in),
    .pin_inpad            (pin_inpad),
    .gfpga_pad_io_soc_out (soc_out),
    .gfpga_pad_io_soc_dir (soc_dir),
    .ccff_tail            (ccff_tail),
    .cfg_done             (cfg_done)
  );

  function automatic bit chain_bit(input int i);
    return (i < q.size()) ? q[i] : 1'b0;
  endfunction

  // Expected {pin_inpad, soc_out, soc_dir, ccff_tail, cfg_done}
  function automatic logic [13:0] model_outs();
    logic [NS-1:0] p, o, d;
    bit oe, inv;
    for (int k = 0; k < NS; k++) begin
      oe   = SHADOW ? m_shadow[k*CB]     : chain_bit(k*CB);
      inv  = SHADOW ? m_shadow[k*CB + 1] : chain_bit(k*CB + 1);
      d[k] = !(oe && isol_n);
      o[k] = isol_n && pin_outpad[k];
      p[k] = isol_n && (soc_in[k] ^ inv);
    end
    return {p, o, d, chain_bit(TOTAL-1), (m_cnt == TOTAL)};
  endfunction

  function automatic logic [13:0] dut_outs();
    return {pin_inpad, soc_out, soc_dir, ccff_tail, cfg_done};
  endfunction

  // Drives one clock edge and advances the model by that edge's rules.
  task automatic clk_edge(input bit rst, input bit sh, input bit head, input bit cm);
    @(negedge prog_clk);
    prog_reset    = rst;
    ccff_shift_en = sh;
    ccff_head     = head;
    cfg_commit    = cm;
    @(posedge prog_clk);
    if (rst) begin
      q.delete();
      foreach (m_shadow[i]) m_shadow[i] = 1'b0;
      m_cnt = 0;
    end else begin
      if (cm) begin
        for (int i = 0; i < TOTAL; i++) m_shadow[i] = chain_bit(i);
        m_cnt = 0;
      end else if (sh && m_cnt < TOTAL) begin
        m_cnt++;
      end
      if (sh) begin
        q.push_front(head);
        if (q.size() > TOTAL) void'(q.pop_back());
      end
    end
    #1;
    prog_reset    = 1'b0;
    ccff_shift_en = 1'b0;
    cfg_commit    = 1'b0;
  endtask

  task automatic test_reset();
    isol_n = 1'b1; soc_in = 4'b1010; pin_outpad = 4'b0110;
    clk_edge(1, 0, 0, 0);
    clk_edge(1, 0, 0, 0);
    clk_edge(0, 0, 0, 0);
    checks++;
    if (soc_dir !== 4'b1111) begin failures++;
      $display("FAIL reset_dir got=%b exp=1111", soc_dir); end
    checks++;
    if (ccff_tail !== 1'b0 || cfg_done !== 1'b0) begin failures++;
      $display("FAIL reset_tail_done got=%b%b exp=00", ccff_tail, cfg_done); end
    checks++;
    if (pin_inpad !== 4'b1010 || soc_out !== 4'b0110) begin failures++;
      $display("FAIL reset_data got_in=%b got_out=%b exp=1010/0110", pin_inpad, soc_out); end
  endtask

  task automatic test_directed_load();
    bit seq [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    soc_in = 4'b0000; isol_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clk_edge(0, 1, seq[i], 0);
      checks++;
      if (cfg_done !== (i == 7)) begin failures++;
        $display("FAIL load_done shift=%0d got=%b exp=%b", i + 1, cfg_done, (i == 7)); end
    end
    clk_edge(0, 0, 0, 1);
    checks++;
    if (cfg_done !== 1'b0) begin failures++;
      $display("FAIL commit_done got=%b exp=0", cfg_done); end
    checks++;
    if (soc_dir !== 4'b1110 || pin_inpad !== 4'b1000) begin failures++;
      $display("FAIL commit_cfg got_dir=%b got_in=%b exp=1110/1000", soc_dir, pin_inpad); end
    checks++;
    if (dut_outs() !== model_outs()) begin failures++;
      $display("FAIL commit_model got=%h exp=%h", dut_outs(), model_outs()); end
  endtask

  task automatic test_hold();
    logic [NS-1:0] dir0, in0;
    dir0 = soc_dir; in0 = pin_inpad;
    for (int i = 0; i < 3; i++) begin
      clk_edge(0, 1, 1'($urandom_range(0, 1)), 0);
      checks++;
      if (dut_outs() !== model_outs()) begin failures++;
        $display("FAIL hold_model shift=%0d got=%h exp=%h", i, dut_outs(), model_outs()); end
      if (SHADOW) begin
        checks++;
        if (soc_dir !== dir0 || pin_inpad !== in0) begin failures++;
          $display("FAIL hold_stable got=%b/%b exp=%b/%b", soc_dir, pin_inpad, dir0, in0); end
      end
    end
  endtask

  task automatic test_isolation();
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      isol_n = 1'b0; pin_outpad = 4'($urandom); soc_in = 4'($urandom);
      #1;
      checks++;
      if (soc_dir !== 4'b1111 || soc_out !== 4'b0000 || pin_inpad !== 4'b0000) begin
        failures++;
        $display("FAIL isolation got_dir=%b got_out=%b got_in=%b exp=1111/0000/0000",
                 soc_dir, soc_out, pin_inpad);
      end
    end
    isol_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) clk_edge(0, 1, 1'b1, 0);
    clk_edge(1, 1, 1'b1, 1);
    checks++;
    if (soc_dir !== 4'b1111 || ccff_tail !== 1'b0 || cfg_done !== 1'b0) begin failures++;
      $display("FAIL reset_mid got_dir=%b tail=%b done=%b exp=1111/0/0",
               soc_dir, ccff_tail, cfg_done); end
    for (int i = 0; i < 8; i++) begin
      clk_edge(0, 1, 1'($urandom_range(0, 1)), 0);
      checks++;
      if (cfg_done !== (i == 7)) begin failures++;
        $display("FAIL reload_done shift=%0d got=%b exp=%b", i + 1, cfg_done, (i == 7)); end
    end
    clk_edge(0, 0, 0, 1);
    checks++;
    if (dut_outs() !== model_outs()) begin failures++;
      $display("FAIL reload_model got=%h exp=%h", dut_outs(), model_outs()); end
  endtask

  task automatic test_enable_toggle();
    bit tail0;
    clk_edge(0, 1, 1'b1, 0);
    tail0 = ccff_tail;
    clk_edge(0, 0, ~tail0, 0);
    checks++;
    if (ccff_tail !== tail0 || dut_outs() !== model_outs()) begin failures++;
      $display("FAIL disabled_edge got=%h exp=%h", dut_outs(), model_outs()); end
    clk_edge(0, 1, 1'b0, 0);
    for (int i = 0; i < 6; i++) clk_edge(0, 1, 1'($urandom_range(0, 1)), 0);
    clk_edge(0, 1, 1'b1, 1);   // coincident commit and shift
    checks++;
    if (cfg_done !== 1'b0 || dut_outs() !== model_outs()) begin failures++;
      $display("FAIL coincident got=%h exp=%h", dut_outs(), model_outs()); end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) clk_edge(0, 0, 1'b0, 0);
      clk_edge(0, 1, 1'($urandom_range(0, 1)), 0);
      checks++;
      if (cfg_done !== (i == 7)) begin failures++;
        $display("FAIL recount_done shift=%0d got=%b exp=%b", i + 1, cfg_done, (i == 7)); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge prog_clk);
      isol_n     = ($urandom_range(0, 7) != 0);
      pin_outpad = 4'($urandom);
      soc_in     = 4'($urandom);
      clk_edge(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      checks++;
      if (dut_outs() !== model_outs()) begin failures++;
        $display("FAIL random n=%0d got=%h exp=%h", n, dut_outs(), model_outs()); end
    end
  endtask

  initial begin
    prog_reset = 1'b1; ccff_head = 1'b0; ccff_shift_en = 1'b0; cfg_commit = 1'b0;
    isol_n = 1'b1; pin_outpad = '0; soc_in = '0; m_cnt = 0;
    test_reset();
    test_directed_load();
    test_hold();
    test_isolation();
    test_reset_mid();
    test_enable_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
